// File: rtl/tank_bullet_if.sv
// Signal bundle between a tank controller, the bullet engine and the video/collision logic.
interface tank_bullet_if;
  logic       frame_clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] tank_X;
  logic [9:0] tank_Y;
  logic [2:0] tank_dir;
  logic       fire;
  logic       hit;
  logic       fire_ack;
  logic       bullet_active;
  logic [9:0] bullet_X;
  logic [9:0] bullet_Y;
  logic [2:0] bullet_dir;
  logic       is_bullet;

  modport master (
    output frame_clk, DrawX, DrawY, tank_X, tank_Y, tank_dir, fire, hit,
    input  fire_ack, bullet_active, bullet_X, bullet_Y, bullet_dir, is_bullet
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, tank_X, tank_Y, tank_dir, fire, hit,
    output fire_ack, bullet_active, bullet_X, bullet_Y, bullet_dir, is_bullet
  );
endinterface

// File: rtl/tank_bullet.sv
// Single-bullet projectile engine: launch from the tank edge, advance once per frame tick.
// Optional post-retire lockout is built when TANK_BULLET_COOLDOWN_EN is defined.
module tank_bullet #(
  parameter int unsigned Size  = 4,
  parameter int unsigned Speed = 4,
  parameter int unsigned X_Max = 639,
  parameter int unsigned Y_Max = 479
`ifdef TANK_BULLET_COOLDOWN_EN
  , parameter int unsigned Cooldown_Frames = 30
`endif
) (
  input logic          Clk,
  input logic          Reset,
  tank_bullet_if.slave bus
);

  typedef logic signed [10:0] pos_t;

  localparam pos_t SizeS  = pos_t'(Size);
  localparam pos_t SpeedS = pos_t'(Speed);

`ifdef TANK_BULLET_COOLDOWN_EN
  localparam int unsigned CntW = $clog2(Cooldown_Frames + 1);
  typedef enum logic [1:0] {StIdle, StFlying, StCooldown} state_e;
  logic [CntW-1:0] cnt_q;
`else
  typedef enum logic [0:0] {StIdle, StFlying} state_e;
`endif

  state_e     state_q;
  logic       frame_q, tick_q;
  logic [9:0] x_q, y_q;
  logic [2:0] dir_q;
  logic       active_q, ack_q;

  pos_t tx, ty, bx, by, spawn_x, spawn_y, next_x, next_y;
  logic dir_ok, spawn_ok, next_ok, retire;

  // Whole Size x Size span must sit inside the screen; widened so +Size-1 cannot wrap.
  function automatic logic fits(pos_t x, pos_t y);
    logic signed [11:0] xe, ye;
    xe = {x[10], x};
    ye = {y[10], y};
    return !xe[11] && !ye[11] &&
           (xe + $signed(12'(Size - 1)) <= $signed(12'(X_Max))) &&
           (ye + $signed(12'(Size - 1)) <= $signed(12'(Y_Max)));
  endfunction

  always_comb begin
    tx      = $signed({1'b0, bus.tank_X});
    ty      = $signed({1'b0, bus.tank_Y});
    bx      = $signed({1'b0, x_q});
    by      = $signed({1'b0, y_q});
    spawn_x = tx;
    spawn_y = ty;
    dir_ok  = 1'b1;
    case (bus.tank_dir)
      3'd1:    begin spawn_x = tx + 11'sd14; spawn_y = ty - SizeS;   end
      3'd2:    begin spawn_x = tx + 11'sd33; spawn_y = ty + 11'sd14; end
      3'd3:    begin spawn_x = tx - SizeS;   spawn_y = ty + 11'sd14; end
      3'd4:    begin spawn_x = tx + 11'sd14; spawn_y = ty + 11'sd33; end
      default: dir_ok = 1'b0;
    endcase
    next_x = bx;
    next_y = by;
    case (dir_q)
      3'd1:    next_y = by - SpeedS;
      3'd2:    next_x = bx + SpeedS;
      3'd3:    next_x = bx - SpeedS;
      3'd4:    next_y = by + SpeedS;
      default: ;
    endcase
    spawn_ok = fits(spawn_x, spawn_y);
    next_ok  = fits(next_x, next_y);
    // hit takes priority over a same-cycle move
    retire   = bus.hit || (tick_q && !next_ok);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_q  <= 1'b0;
      tick_q   <= 1'b0;
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= 3'd1;
      active_q <= 1'b0;
      ack_q    <= 1'b0;
`ifdef TANK_BULLET_COOLDOWN_EN
      cnt_q    <= '0;
`endif
    end else begin
      frame_q <= bus.frame_clk;
      tick_q  <= bus.frame_clk & ~frame_q;
      ack_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tick_q && bus.fire && dir_ok && spawn_ok) begin
            x_q      <= spawn_x[9:0];
            y_q      <= spawn_y[9:0];
            dir_q    <= bus.tank_dir;
            active_q <= 1'b1;
            ack_q    <= 1'b1;
            state_q  <= StFlying;
          end
        end
        StFlying: begin
          if (retire) begin
            active_q <= 1'b0;
`ifdef TANK_BULLET_COOLDOWN_EN
            cnt_q    <= CntW'(Cooldown_Frames);
            state_q  <= StCooldown;
`else
            state_q  <= StIdle;
`endif
          end else if (tick_q) begin
            x_q <= next_x[9:0];
            y_q <= next_y[9:0];
          end
        end
`ifdef TANK_BULLET_COOLDOWN_EN
        StCooldown: begin
          if (tick_q) begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fire_ack      = ack_q;
  assign bus.bullet_active = active_q;
  assign bus.bullet_X      = x_q;
  assign bus.bullet_Y      = y_q;
  assign bus.bullet_dir    = dir_q;

  always_comb begin
    bus.is_bullet = active_q &&
                    ({1'b0, bus.DrawX} >= {1'b0, x_q}) &&
                    ({1'b0, bus.DrawX} <= {1'b0, x_q} + 11'(Size - 1)) &&
                    ({1'b0, bus.DrawY} >= {1'b0, y_q}) &&
                    ({1'b0, bus.DrawY} <= {1'b0, y_q} + 11'(Size - 1));
  end

endmodule

// File: tb/tb_tank_bullet.sv
// Self-checking bench for tank_bullet; expected positions go through a scoreboard queue.
module tb_tank_bullet;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  tank_bullet_if bus ();

`ifdef TANK_BULLET_COOLDOWN_EN
  localparam int RefireFrames = 4;
  tank_bullet #(.Cooldown_Frames(3)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
`else
  localparam int RefireFrames = 1;
  tank_bullet dut (.Clk(Clk), .Reset(Reset), .bus(bus));
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } xy_t;

  xy_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  ack_cnt;
  int  ack_at;

  // One frame period: frame_clk high 4 cycles, low 4 cycles; fire_ack pulses are counted.
  task automatic run_frame();
    ack_cnt = 0;
    ack_at  = -1;
    bus.frame_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (bus.fire_ack === 1'b1) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = i;
      end
      if (i == 3) bus.frame_clk = 1'b0;
    end
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) run_frame();
  endtask

  task automatic kill();
    @(negedge Clk);
    bus.hit = 1'b1;
    @(negedge Clk);
    bus.hit = 1'b0;
  endtask

  task automatic launch(input int tx, input int ty, input int dir);
    bus.tank_X = 10'(tx);
    bus.tank_Y = 10'(ty);
    bus.tank_dir = 3'(dir);
    bus.fire = 1'b1;
    run_frame();
    bus.fire = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    bus.fire = 1'b0;
    bus.hit = 1'b0;
    bus.tank_X = '0;
    bus.tank_Y = '0;
    bus.tank_dir = 3'd1;
    bus.DrawX = '0;
    bus.DrawY = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    total++; if (bus.bullet_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", bus.bullet_active); end
    total++; if (bus.bullet_X !== 10'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", bus.bullet_X); end
    total++; if (bus.bullet_Y !== 10'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", bus.bullet_Y); end
    total++; if (bus.bullet_dir !== 3'd1) begin bad++; $display("FAIL reset_dir: got %0d want 1", bus.bullet_dir); end
    total++; if (bus.fire_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.fire_ack); end
    total++; if (bus.is_bullet !== 1'b0) begin bad++; $display("FAIL reset_is_bullet: got %b want 0", bus.is_bullet); end
  endtask

  task automatic test_launch_up();
    xy_t e;
    int dx[5] = '{114, 117, 118, 113, 114};
    int dy[5] = '{376, 379, 376, 376, 380};
    logic ex[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_q.push_back('{x: 10'd114, y: 10'd376});
    launch(100, 380, 1);
    total++;
    if (ack_cnt != 1 || ack_at != 1) begin
      bad++; $display("FAIL launch_ack: pulses=%0d at=%0d want pulses=1 at=1", ack_cnt, ack_at);
    end
    e = exp_q.pop_front();
    total++; if (bus.bullet_X !== e.x) begin bad++; $display("FAIL launch_x: got %0d want %0d", bus.bullet_X, e.x); end
    total++; if (bus.bullet_Y !== e.y) begin bad++; $display("FAIL launch_y: got %0d want %0d", bus.bullet_Y, e.y); end
    total++; if (bus.bullet_active !== 1'b1) begin bad++; $display("FAIL launch_active: got %b want 1", bus.bullet_active); end
    total++; if (bus.bullet_dir !== 3'd1) begin bad++; $display("FAIL launch_dir: got %0d want 1", bus.bullet_dir); end
    for (int i = 0; i < 5; i++) begin
      bus.DrawX = 10'(dx[i]);
      bus.DrawY = 10'(dy[i]);
      #1;
      total++;
      if (bus.is_bullet !== ex[i]) begin
        bad++; $display("FAIL is_bullet(%0d,%0d): got %b want %b", dx[i], dy[i], bus.is_bullet, ex[i]);
      end
    end
    bus.DrawX = '0;
    bus.DrawY = '0;
  endtask

  task automatic test_flight_up();
    xy_t e;
    int y = 376;
    // tank moves after launch; the bullet must not follow
    bus.tank_X = 10'd500;
    bus.tank_Y = 10'd50;
    bus.tank_dir = 3'd2;
    while (y >= 4) begin
      y -= 4;
      exp_q.push_back('{x: 10'd114, y: 10'(y)});
      run_frame();
      e = exp_q.pop_front();
      total++;
      if (bus.bullet_X !== e.x || bus.bullet_Y !== e.y || bus.bullet_active !== 1'b1) begin
        bad++; $display("FAIL flight_step: got (%0d,%0d) act=%b want (%0d,%0d) act=1",
                        bus.bullet_X, bus.bullet_Y, bus.bullet_active, e.x, e.y);
      end
    end
    run_frame();
    total++; if (bus.bullet_active !== 1'b0) begin bad++; $display("FAIL flight_retire: active=%b want 0", bus.bullet_active); end
    total++;
    if (bus.bullet_X !== 10'd114 || bus.bullet_Y !== 10'd0) begin
      bad++; $display("FAIL flight_hold: got (%0d,%0d) want (114,0)", bus.bullet_X, bus.bullet_Y);
    end
    idle_frames(4);
  endtask

  task automatic test_spawn_bounds();
    xy_t e;
    int tx[8]  = '{620, 604, 603, 100, 100, 0,   100, 100};
    int ty[8]  = '{200, 200, 200, 3,   4,   100, 444, 443};
    int dr[8]  = '{2,   2,   2,   1,   1,   3,   4,   4};
    int acc[8] = '{0,   0,   1,   0,   1,   0,   0,   1};
    int ex[8]  = '{0,   0,   636, 0,   114, 0,   0,   114};
    int ey[8]  = '{0,   0,   214, 0,   0,   0,   0,   476};
    for (int i = 0; i < 8; i++) begin
      if (acc[i] != 0) exp_q.push_back('{x: 10'(ex[i]), y: 10'(ey[i])});
      launch(tx[i], ty[i], dr[i]);
      total++;
      if (ack_cnt != acc[i] || bus.bullet_active !== (acc[i] != 0)) begin
        bad++; $display("FAIL spawn_accept[%0d]: ack=%0d act=%b want ack=%0d", i, ack_cnt,
                        bus.bullet_active, acc[i]);
      end
      if (acc[i] != 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (bus.bullet_X !== e.x || bus.bullet_Y !== e.y) begin
          bad++; $display("FAIL spawn_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", i, bus.bullet_X,
                          bus.bullet_Y, e.x, e.y);
        end
        kill();
        idle_frames(4);
      end
    end
  endtask

  task automatic test_hit();
    launch(100, 100, 2);
    bus.frame_clk = 1'b1;
    @(negedge Clk);
    bus.hit = 1'b1;  // coincides with the tick edge
    @(negedge Clk);
    bus.hit = 1'b0;
    total++; if (bus.bullet_active !== 1'b0) begin bad++; $display("FAIL hit_tick_active: got %b want 0", bus.bullet_active); end
    total++;
    if (bus.bullet_X !== 10'd133 || bus.bullet_Y !== 10'd114) begin
      bad++; $display("FAIL hit_tick_pos: got (%0d,%0d) want (133,114)", bus.bullet_X, bus.bullet_Y);
    end
    repeat (2) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    idle_frames(4);
    launch(300, 300, 3);
    total++; if (bus.bullet_X !== 10'd296) begin bad++; $display("FAIL left_spawn_x: got %0d want 296", bus.bullet_X); end
    kill();
    total++; if (bus.bullet_active !== 1'b0) begin bad++; $display("FAIL hit_no_tick: active=%b want 0", bus.bullet_active); end
    idle_frames(4);
  endtask

  task automatic test_refire();
    xy_t e;
    int flight_acks = 0;
    int k;
    bus.tank_X = 10'd100;
    bus.tank_Y = 10'd40;
    bus.tank_dir = 3'd1;
    bus.fire = 1'b1;
    run_frame();
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL refire_first_ack: got %0d want 1", ack_cnt); end
    for (int i = 0; i < 20; i++) begin
      run_frame();
      flight_acks += ack_cnt;
      if (bus.bullet_active !== 1'b1) break;
    end
    total++; if (flight_acks != 0 || bus.bullet_active !== 1'b0) begin
      bad++; $display("FAIL refire_flight: acks=%0d act=%b want acks=0 act=0", flight_acks, bus.bullet_active);
    end
    exp_q.push_back('{x: 10'd114, y: 10'd36});
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      run_frame();
      if (ack_cnt > 0) begin k = i; break; end
    end
    total++; if (k != RefireFrames) begin bad++; $display("FAIL refire_frames: got %0d want %0d", k, RefireFrames); end
    e = exp_q.pop_front();
    total++;
    if (bus.bullet_X !== e.x || bus.bullet_Y !== e.y) begin
      bad++; $display("FAIL refire_pos: got (%0d,%0d) want (%0d,%0d)", bus.bullet_X, bus.bullet_Y, e.x, e.y);
    end
    bus.fire = 1'b0;
    kill();
    idle_frames(4);
  endtask

  task automatic test_reset_mid_flight();
    launch(167, 136, 2);
    bus.DrawX = 10'd201;
    bus.DrawY = 10'd151;
    #1;
    total++; if (bus.is_bullet !== 1'b1) begin bad++; $display("FAIL midrst_pre_pixel: got %b want 1", bus.is_bullet); end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    total++;
    if (bus.bullet_active !== 1'b0 || bus.bullet_X !== 10'd0 || bus.bullet_Y !== 10'd0 ||
        bus.bullet_dir !== 3'd1 || bus.fire_ack !== 1'b0 || bus.is_bullet !== 1'b0) begin
      bad++; $display("FAIL midrst_clear: act=%b x=%0d y=%0d dir=%0d ack=%b pix=%b want 0/0/0/1/0/0",
                      bus.bullet_active, bus.bullet_X, bus.bullet_Y, bus.bullet_dir,
                      bus.fire_ack, bus.is_bullet);
    end
    @(negedge Clk);
    Reset = 1'b0;
    bus.DrawX = '0;
    bus.DrawY = '0;
    @(negedge Clk);
  endtask

  task automatic test_bad_dir();
    int dirs[4] = '{0, 5, 6, 7};
    for (int i = 0; i < 4; i++) begin
      launch(100, 100, dirs[i]);
      total++;
      if (ack_cnt != 0 || bus.bullet_active !== 1'b0) begin
        bad++; $display("FAIL bad_dir[%0d]: ack=%0d act=%b want 0/0", dirs[i], ack_cnt, bus.bullet_active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_launch_up();
    test_flight_up();
    test_spawn_bounds();
    test_hit();
    test_refire();
    test_reset_mid_flight();
    test_bad_dir();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
